// File: rtl/sram_responder_if.sv
// Controller-side RAM command signals plus the boot loader handshake.
// Latency: none, plain wires.
// Backpressure: loader words are taken only while ld_ready is high; RAM cycles are never stalled.
//
// Signals:
//   ram_addr / ram_wre       controller word address and read(1)/write(0) select
//   ld_valid / ld_ready      loader handshake, word accepted when both are high on a clock edge
//   ld_addr / ld_data / ld_last  loader word index, payload and end-of-image marker
interface sram_responder_if #(
    parameter int AW = 12
) ();
    logic [17:0]   ram_addr;
    logic          ram_wre;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic          ld_last;

    // Controller and loader side.
    modport master (
        output ram_addr, ram_wre, ld_valid, ld_addr, ld_data, ld_last,
        input  ld_ready
    );

    // Responder side.
    modport slave (
        input  ram_addr, ram_wre, ld_valid, ld_addr, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/sram_responder.sv
// RAM target for the controller's 16-bit port: word array, boot loader and read/write cycle counters.
// Latency: reads are combinational (same cycle); writes and loader words commit on the rising edge.
// Backpressure: loader is accepted every cycle in LOAD and never in RUN; RAM cycles are never stalled.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   bus (slave)       ram_addr/ram_wre from the controller, loader handshake (ld_*)
//   ram_data          shared 16-bit bus, driven here only for reads in RUN
//   ram_ready         high while in RUN
//   rd_count/wr_count saturating counts of RUN read and write cycles
module sram_responder #(
    parameter int AW      = 12,
    parameter bit BOOT_EN = 1'b1,
    parameter int CNT_W   = 24
) (
    input  logic              clock,
    input  logic              reset,
    sram_responder_if.slave   bus,
    inout  wire  [15:0]       ram_data,
    output logic              ram_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = BOOT_EN ? S_LOAD : S_RUN;

    state_t        state;
    logic [15:0]   mem [0:DEPTH-1];

    logic [AW-1:0] ram_idx;
    logic          is_write;
    logic          in_run;
    logic          in_load;
    logic          ld_accept;
    logic          run_write;
    logic          drive_en;

    // Upper address bits are ignored, so the array aliases every 2**AW words.
    assign ram_idx = bus.ram_addr[AW-1:0];

    // Only a clean 0 is a write; an X/Z select falls to the read side so the
    // array is never written from an undefined command.
    assign is_write = (bus.ram_wre === 1'b0);

    // The state register already holds its reset value while reset is low;
    // gating with reset keeps both status outputs low for the whole reset
    // window, including the BOOT_EN=0 case where the reset state is RUN, and
    // lets ram_ready drop the instant reset is asserted.
    assign in_run  = (state == S_RUN)  && reset;
    assign in_load = (state == S_LOAD) && reset;

    assign ram_ready    = in_run;
    assign bus.ld_ready = in_load;

    assign ld_accept = in_load && bus.ld_valid;
    assign run_write = in_run && is_write;

    // Release of the bus follows ram_wre combinationally so there is no
    // overlap with the controller's write drive.
    assign drive_en = in_run && !is_write;
    assign ram_data = drive_en ? mem[ram_idx] : {16{1'bz}};

    // Boot FSM: LOAD until the loader hands over its last word, then RUN
    // until the next reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
        end else if (state == S_LOAD && bus.ld_valid && bus.ld_last) begin
            state <= S_RUN;
        end
    end

    // Exactly one counter advances per RUN cycle; both stick at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == S_RUN) begin
            if (is_write) begin
                if (!(&wr_count)) begin
                    wr_count <= wr_count + 1'b1;
                end
            end else begin
                if (!(&rd_count)) begin
                    rd_count <= rd_count + 1'b1;
                end
            end
        end
    end

    // Array has no reset so boot contents survive a warm reset. Both enables
    // include the reset level, so an edge that lands while reset is asserted
    // writes nothing.
    always_ff @(posedge clock) begin
        if (ld_accept) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end else if (run_write) begin
            mem[ram_idx] <= ram_data;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: boot load, RUN read/write table,
// randomized traffic against an array model, warm reset, and counter saturation.
module tb_sram_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT A: AW=12, BOOT_EN=1, CNT_W=24 ----------------
    logic        reset_a;
    wire  [15:0] bus_a;
    logic        tb_oe;
    logic [15:0] tb_dat;
    logic        ready_a;
    logic [23:0] rdc_a, wrc_a;

    sram_responder_if #(.AW(12)) ifa ();
    assign bus_a = tb_oe ? tb_dat : {16{1'bz}};

    sram_responder #(.AW(12), .BOOT_EN(1'b1), .CNT_W(24)) dut_a (
        .clock     (clock),
        .reset     (reset_a),
        .bus       (ifa),
        .ram_data  (bus_a),
        .ram_ready (ready_a),
        .rd_count  (rdc_a),
        .wr_count  (wrc_a)
    );

    // ---------------- DUT B: AW=12, BOOT_EN=0, CNT_W=4 ----------------
    logic        reset_b;
    wire  [15:0] bus_b;
    logic        ready_b;
    logic [3:0]  rdc_b, wrc_b;

    sram_responder_if #(.AW(12)) ifb ();

    sram_responder #(.AW(12), .BOOT_EN(1'b0), .CNT_W(4)) dut_b (
        .clock     (clock),
        .reset     (reset_b),
        .bus       (ifb),
        .ram_data  (bus_b),
        .ram_ready (ready_b),
        .rd_count  (rdc_b),
        .wr_count  (wrc_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: word array keyed by index (only written words are
    // known) plus plain cycle tallies.
    logic [15:0] ref_mem [int];
    int          ref_rd = 0;
    int          ref_wr = 0;

    // One RUN cycle on DUT A. Called at posedge+1; samples the bus mid-cycle,
    // returns at the next posedge+1 with the model updated.
    task automatic run_cycle(input logic wre, input logic [17:0] addr,
                             input logic [15:0] wdat, output logic [15:0] seen);
        ifa.ram_wre  = wre;
        ifa.ram_addr = addr;
        tb_oe        = !wre;
        tb_dat       = wdat;
        @(negedge clock);
        seen = bus_a;
        @(posedge clock);
        #1;
        if (!wre) begin
            ref_mem[int'(addr[11:0])] = wdat;
            ref_wr++;
        end else begin
            ref_rd++;
        end
        tb_oe = 1'b0;
    endtask

    typedef struct {
        logic        wre;
        logic [17:0] addr;
        logic [15:0] dat;
        logic [15:0] exp;   // expected bus value seen mid-cycle
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [15:0] seen;
        logic [11:0] idx;
        logic [17:0] addr;
        logic [15:0] dat;
        logic        wre;

        // Directed RUN table: reads return array data, writes show only the
        // controller's own drive on the bus.
        vt[0] = '{1'b1, 18'h00000, 16'h0000, 16'h1234};
        vt[1] = '{1'b1, 18'h00001, 16'h0000, 16'hABCD};
        vt[2] = '{1'b0, 18'h00010, 16'hDEAD, 16'hDEAD};
        vt[3] = '{1'b0, 18'h00011, 16'hBEEF, 16'hBEEF};
        vt[4] = '{1'b1, 18'h00010, 16'h0000, 16'hDEAD};
        vt[5] = '{1'b1, 18'h00011, 16'h0000, 16'hBEEF};
        vt[6] = '{1'b0, 18'h01000, 16'h5A5A, 16'h5A5A};
        vt[7] = '{1'b1, 18'h00000, 16'h0000, 16'h5A5A};
        vt[8] = '{1'b0, 18'h00005, 16'h1111, 16'h1111};
        vt[9] = '{1'b1, 18'h00005, 16'h0000, 16'h1111};

        reset_a      = 1'b0;
        reset_b      = 1'b0;
        tb_oe        = 1'b1;
        tb_dat       = 16'h0000;
        ifa.ram_wre  = 1'b1;
        ifa.ram_addr = 18'h0;
        ifa.ld_valid = 1'b0;
        ifa.ld_addr  = 12'h0;
        ifa.ld_data  = 16'h0;
        ifa.ld_last  = 1'b0;
        ifb.ram_wre  = 1'b1;
        ifb.ram_addr = 18'h3;
        ifb.ld_valid = 1'b0;
        ifb.ld_addr  = 12'h0;
        ifb.ld_data  = 16'h0;
        ifb.ld_last  = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_ram_ready", 32'(ready_a), 32'd0);
        chk("rst_ld_ready",  32'(ifa.ld_ready), 32'd0);
        chk("rst_rd_count",  32'(rdc_a), 32'd0);
        chk("rst_wr_count",  32'(wrc_a), 32'd0);
        chk("rst_bus_released", 32'(bus_a), 32'h0000);

        @(posedge clock);
        #1;
        reset_a = 1'b1;
        #1;
        chk("load_ld_ready", 32'(ifa.ld_ready), 32'd1);
        chk("load_ram_ready", 32'(ready_a), 32'd0);

        // ---- boot load: two words ----
        ifa.ld_valid = 1'b1;
        ifa.ld_addr  = 12'h000;
        ifa.ld_data  = 16'h1234;
        ifa.ld_last  = 1'b0;
        @(posedge clock);
        #1;
        // Still LOAD: word 0 now holds 0x1234, bus must stay released.
        chk("load_mid_ram_ready", 32'(ready_a), 32'd0);
        chk("load_mid_ld_ready", 32'(ifa.ld_ready), 32'd1);
        chk("load_bus_released", 32'(bus_a), 32'h0000);
        chk("load_counters_hold", 32'(rdc_a) + 32'(wrc_a), 32'd0);
        ifa.ld_addr = 12'h001;
        ifa.ld_data = 16'hABCD;
        ifa.ld_last = 1'b1;
        @(posedge clock);
        #1;
        chk("boot_ram_ready", 32'(ready_a), 32'd1);
        chk("boot_ld_ready",  32'(ifa.ld_ready), 32'd0);
        // Loader left asserted in RUN: it must have no effect on the array.
        ifa.ld_last = 1'b0;
        ifa.ld_addr = 12'h025;
        ifa.ld_data = 16'hFFFF;
        tb_oe = 1'b0;
        ref_mem[0] = 16'h1234;
        ref_mem[1] = 16'hABCD;

        // ---- directed RUN table ----
        for (int i = 0; i < 10; i++) begin
            run_cycle(vt[i].wre, vt[i].addr, vt[i].dat, seen);
            chk($sformatf("vec%0d_bus", i), 32'(seen), 32'(vt[i].exp));
            if (i == 5) begin
                chk("store_pair_wr_count", 32'(wrc_a), 32'd2);
                chk("store_pair_rd_count", 32'(rdc_a), 32'd4);
            end
        end
        chk("table_rd_count", 32'(rdc_a), 32'd6);
        chk("table_wr_count", 32'(wrc_a), 32'd4);

        // ---- randomized traffic over aliased addresses ----
        for (int n = 0; n < 300; n++) begin
            wre  = 1'($urandom_range(0, 1));
            idx  = 12'h020 + 12'($urandom_range(0, 15));
            addr = {6'($urandom_range(0, 63)), idx};
            dat  = 16'($urandom);
            if (!wre) begin
                run_cycle(1'b0, addr, dat, seen);
                chk("rand_write_bus", 32'(seen), 32'(dat));
            end else if (ref_mem.exists(int'(idx))) begin
                run_cycle(1'b1, addr, 16'h0, seen);
                chk("rand_read", 32'(seen), 32'(ref_mem[int'(idx)]));
            end else begin
                run_cycle(1'b1, addr, 16'h0, seen);
            end
        end
        chk("rand_rd_count", 32'(rdc_a), 32'(ref_rd));
        chk("rand_wr_count", 32'(wrc_a), 32'(ref_wr));

        // ---- warm reset in RUN ----
        ifa.ld_valid = 1'b0;
        ifa.ram_wre  = 1'b1;
        ifa.ram_addr = 18'h00005;
        tb_oe  = 1'b1;
        tb_dat = 16'h0000;
        reset_a = 1'b0;
        #1;
        chk("warm_rst_ram_ready", 32'(ready_a), 32'd0);
        chk("warm_rst_ld_ready",  32'(ifa.ld_ready), 32'd0);
        chk("warm_rst_rd_count",  32'(rdc_a), 32'd0);
        chk("warm_rst_wr_count",  32'(wrc_a), 32'd0);
        chk("warm_rst_bus_released", 32'(bus_a), 32'h0000);
        @(posedge clock);
        #1;
        reset_a = 1'b1;
        #1;
        chk("reload_ld_ready", 32'(ifa.ld_ready), 32'd1);
        chk("reload_ram_ready", 32'(ready_a), 32'd0);
        chk("reload_bus_released", 32'(bus_a), 32'h0000);
        ifa.ld_valid = 1'b1;
        ifa.ld_addr  = 12'h009;
        ifa.ld_data  = 16'h0909;
        ifa.ld_last  = 1'b1;
        @(posedge clock);
        #1;
        ifa.ld_valid = 1'b0;
        ifa.ld_last  = 1'b0;
        tb_oe = 1'b0;
        chk("reload_done_ram_ready", 32'(ready_a), 32'd1);
        run_cycle(1'b1, 18'h00005, 16'h0, seen);
        chk("retained_addr5", 32'(seen), 32'h1111);
        run_cycle(1'b1, 18'h00009, 16'h0, seen);
        chk("reloaded_addr9", 32'(seen), 32'h0909);
        chk("post_reload_rd_count", 32'(rdc_a), 32'd2);
        chk("post_reload_wr_count", 32'(wrc_a), 32'd0);

        // ---- DUT B: no boot, 4-bit saturating counters ----
        chk("b_rst_ram_ready", 32'(ready_b), 32'd0);
        reset_b = 1'b1;
        #1;
        chk("b_run_ram_ready", 32'(ready_b), 32'd1);
        chk("b_run_ld_ready",  32'(ifb.ld_ready), 32'd0);
        chk("b_start_rd_count", 32'(rdc_b), 32'd0);
        repeat (14) @(posedge clock);
        #1;
        chk("b_rd_count_14", 32'(rdc_b), 32'hE);
        repeat (3) @(posedge clock);
        #1;
        chk("b_rd_count_sat", 32'(rdc_b), 32'hF);
        ifb.ram_wre = 1'b0;
        @(posedge clock);
        #1;
        ifb.ram_wre = 1'b1;
        chk("b_wr_count", 32'(wrc_b), 32'd1);
        chk("b_rd_count_held", 32'(rdc_b), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
